// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a UART TX FIFO.
// Whole packets (or MAX_PKT-byte slices) are granted so streams never interleave.

module uart_tx_arb_lane #(
  parameter int DBIT = 8
) (
  input  logic            gnt,
  input  logic            valid,
  input  logic            tx_full,
  input  logic [DBIT-1:0] data,
  output logic            ready,
  output logic            wr,
  output logic [DBIT-1:0] data_m
);
  assign ready  = gnt & ~tx_full;
  assign wr     = ready & valid;
  assign data_m = gnt ? data : '0;
endmodule

module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int MAX_PKT = 16,
  localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW     = $clog2(MAX_PKT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 pkt_trunc
);
  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state, state_nxt;
  logic [GW-1:0]              ptr, sel;
  logic [CW-1:0]              cnt;
  logic [NREQ-1:0]            gnt, lane_wr;
  logic [NREQ-1:0][DBIT-1:0]  lane_data;
  logic                       any_req, last_g, at_lim, rel;

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      gnt[i] = (state == SEND) && (grant_id == GW'(i));
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    uart_tx_arb_lane #(.DBIT(DBIT)) u_lane (
      .gnt     (gnt[i]),
      .valid   (req_valid[i]),
      .tx_full (tx_full),
      .data    (req_data[i*DBIT +: DBIT]),
      .ready   (req_ready[i]),
      .wr      (lane_wr[i]),
      .data_m  (lane_data[i])
    );
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NREQ; i++) w_data |= lane_data[i];
  end

  assign wr_uart = |lane_wr;
  assign last_g  = |(req_last & gnt);
  assign at_lim  = (cnt == CW'(MAX_PKT - 1));
  assign rel     = wr_uart & (last_g | at_lim);
  assign any_req = |req_valid;
  assign busy    = (state == SEND);

  // Rotating scan starting at ptr; first valid requester wins.
  always_comb begin
    logic found;
    found = 1'b0;
    sel   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NREQ) j -= NREQ;
      if (!found && req_valid[j]) begin
        found = 1'b1;
        sel   = GW'(j);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req) state_nxt = SEND;
      SEND: if (rel)     state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      grant_id  <= '0;
      ptr       <= '0;
      cnt       <= '0;
      pkt_trunc <= 1'b0;
    end else begin
      state     <= state_nxt;
      pkt_trunc <= 1'b0;
      if (state == IDLE && any_req) begin
        grant_id <= sel;
        cnt      <= '0;
      end
      if (wr_uart) cnt <= cnt + CW'(1);
      if (rel) begin
        ptr       <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
        // last wins over the limit when both land on the same byte
        pkt_trunc <= ~last_g;
      end
    end
  end
endmodule
